// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing the BRAM wrapper read port among NUM_REQ requesters.
// Optional WAIT timeout enabled by defining RDARB_TIMEOUT_EN.
module bram_read_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          bram_enb,
    output logic [ADDR_WIDTH-1:0]         bram_addrb,
    input  logic                          bram_valid,
    input  logic [DATA_WIDTH-1:0]         bram_doutb
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, ptr, win;
    logic                  found;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_REQ-1:0]    idx_oh;
    logic                  timed_out;

`ifdef RDARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    // cnt counts completed WAIT cycles; the last allowed one is TIMEOUT-1
    assign timed_out = (state == WAIT) && !bram_valid && (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // first set request at or above ptr, wrapping modulo NUM_REQ
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bram_valid || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state  <= IDLE;
            idx    <= '0;
            ptr    <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (found) begin
                    idx    <= win;
                    addr_q <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                end
                WAIT: begin
                    if (bram_valid)     data_q <= bram_doutb;
                    else if (timed_out) data_q <= '0;
                end
                RESP: ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RDARB_TIMEOUT_EN
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            if (bram_valid)     err_q <= 1'b0;
            else if (timed_out) err_q <= 1'b1;
            else                cnt   <= cnt + 1'b1;
        end
    end
    assign rsp_err = (state == RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign idx_oh     = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    assign gnt        = (state == ISSUE) ? idx_oh : '0;
    assign bram_enb   = (state == ISSUE);
    assign bram_addrb = (state == IDLE) ? '0 : addr_q;
    assign rsp_valid  = (state == RESP) ? idx_oh : '0;
    assign rsp_data   = (state == RESP) ? data_q : '0;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: vector table of reads plus reset, stray-valid
// and WAIT-timeout sequences; a behavioural responder models the BRAM wrapper.
module tb_bram_read_arbiter;
    localparam int DW = 16, AW = 16, NR = 4, TO = 15;

    logic iclk = 0, irst = 1;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_addr = {16'h0F0F, 16'h0005, 16'h0203, 16'h0100};
    logic [NR-1:0]    gnt, rsp_valid;
    logic [DW-1:0]    rsp_data, bram_doutb;
    logic [AW-1:0]    bram_addrb;
    logic             rsp_err, busy, bram_enb, bram_valid;

    logic          rv_r = 0, stray_v = 0;
    logic [DW-1:0] rd_r = 16'hDEAD, stray_d = '0, pend = '0;
    int            lat = 1, cd = 0;
    bit            resp_en = 1;
    int            total = 0, bad = 0;

    assign bram_valid = rv_r | stray_v;
    assign bram_doutb = stray_v ? stray_d : rd_r;

    bram_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .iclk(iclk), .irst(irst), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_valid(bram_valid),
        .bram_doutb(bram_doutb));

    always #5 iclk = ~iclk;

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return (a == 16'h0005) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    // wrapper model: valid 'lat' cycles after the enb cycle, data from mem()
    always @(negedge iclk) begin
        rv_r = 1'b0;
        rd_r = 16'hDEAD;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0 && resp_en) begin
                rv_r = 1'b1;
                rd_r = pend;
            end
        end
        if (bram_enb) begin
            cd   = lat;
            pend = mem(bram_addrb);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(negedge iclk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_rspv"}, 32'(rsp_valid), 0);
        chk({nm, "_rspd"}, 32'(rsp_data), 0);
        chk({nm, "_err"}, 32'(rsp_err), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_enb"}, 32'(bram_enb), 0);
        chk({nm, "_addr"}, 32'(bram_addrb), 0);
    endtask

    task automatic do_reset;
        irst = 1'b1;
        step;
        chk_zero("reset");
        irst = 1'b0;
    endtask

    // called at the negedge of IDLE cycle T; returns at the negedge of T+3+L (IDLE)
    task automatic run_txn(input logic [NR-1:0] rq, input int l, input int ei);
        req = rq;
        lat = l;
        chk("idle_busy", 32'(busy), 0);
        step;
        chk("gnt", 32'(gnt), 32'(1) << ei);
        chk("enb", 32'(bram_enb), 1);
        chk("addrb", 32'(bram_addrb), 32'(addr_of(ei)));
        chk("busy_issue", 32'(busy), 1);
        for (int c = 2; c < 2 + l; c++) begin
            step;
            chk("wait_rspv", 32'(rsp_valid), 0);
            chk("wait_busy", 32'(busy), 1);
        end
        step;
        chk("rspv", 32'(rsp_valid), 32'(1) << ei);
        chk("rspd", 32'(rsp_data), 32'(mem(addr_of(ei))));
        chk("rsp_err", 32'(rsp_err), 0);
        chk("busy_resp", 32'(busy), 1);
        step;
    endtask

    typedef struct {
        bit          rst_before;
        logic [NR-1:0] rq;
        int          l;
        int          ei;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'b0100, 3, 2};
        vecs[1]  = '{1'b1, 4'b1111, 1, 0};
        vecs[2]  = '{1'b0, 4'b1111, 1, 1};
        vecs[3]  = '{1'b0, 4'b1111, 1, 2};
        vecs[4]  = '{1'b0, 4'b1111, 1, 3};
        vecs[5]  = '{1'b0, 4'b1111, 1, 0};
        vecs[6]  = '{1'b0, 4'b1010, 1, 1};
        vecs[7]  = '{1'b0, 4'b1010, 2, 3};
        vecs[8]  = '{1'b0, 4'b1010, 1, 1};
        vecs[9]  = '{1'b0, 4'b0001, 2, 0};
        vecs[10] = '{1'b0, 4'b0100, 4, 2};

        step;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst_before) do_reset;
            run_txn(vecs[i].rq, vecs[i].l, vecs[i].ei);
        end
        req = '0;

        // stray valid pulses while idle must not produce a response
        stray_d = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            stray_v = (i % 2 == 0);
            step;
            chk("stray_rspv", 32'(rsp_valid), 0);
            chk("stray_busy", 32'(busy), 0);
        end
        stray_v = 1'b0;

        // reset during WAIT; responder still answers afterwards
        req = 4'b0001;
        lat = 4;
        step;
        chk("rstw_gnt", 32'(gnt), 1);
        req = '0;
        step;
        chk("rstw_busy", 32'(busy), 1);
        irst = 1'b1;
        step;
        chk_zero("rstw");
        irst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("rstw_late_rspv", 32'(rsp_valid), 0);
            chk("rstw_late_busy", 32'(busy), 0);
        end
        // ptr back to 0, so requester 1 wins over 3
        run_txn(4'b1010, 1, 1);

        // silent responder
        resp_en = 1'b0;
        req = 4'b0100;
        step;
        chk("to_gnt", 32'(gnt), 4);
        req = '0;
`ifdef RDARB_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) begin
            step;
            chk("to_wait_rspv", 32'(rsp_valid), 0);
            chk("to_wait_busy", 32'(busy), 1);
        end
        step;
        chk("to_rspv", 32'(rsp_valid), 4);
        chk("to_rspd", 32'(rsp_data), 0);
        chk("to_err", 32'(rsp_err), 1);
        stray_v = 1'b1;
        stray_d = 16'h7777;
        step;
        chk("to_idle_busy", 32'(busy), 0);
        chk("to_idle_rspv", 32'(rsp_valid), 0);
        stray_v = 1'b0;
        step;
        chk("to_late_rspv", 32'(rsp_valid), 0);
        chk("to_late_busy", 32'(busy), 0);
`else
        for (int c = 2; c <= 31; c++) begin
            step;
            chk("nto_busy", 32'(busy), 1);
            chk("nto_err", 32'(rsp_err), 0);
            chk("nto_rspv", 32'(rsp_valid), 0);
        end
        stray_v = 1'b1;
        stray_d = 16'h7777;
        step;
        stray_v = 1'b0;
        chk("nto_rspv_end", 32'(rsp_valid), 4);
        chk("nto_rspd", 32'(rsp_data), 32'h7777);
        chk("nto_err_end", 32'(rsp_err), 0);
        step;
        chk("nto_idle_busy", 32'(busy), 0);
`endif
        resp_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
